decimal_cnt_ctrl: RTL
=====================

# decimal_cnt_ctrl

Run/pause/clear controller for the board's two-digit BCD up-counter (DK1:DK0). Debounces keys S2 (run/pause) and S3 (clear), paces the count with a divided tick, issues single-cycle enable/clear strobes to the counter, and tracks completed 00→LIMIT laps. The counter stays a pure datapath; all sequencing lives here.

## Interface
- TICK_DIV, 5_000_000: clk cycles per count step (0.1 s at 50 MHz); minimum 2
- DEB_CYCLES, 1_000_000: cycles a synchronized key level must be stable to be accepted (20 ms at 50 MHz); minimum 1
- LIMIT_BCD, 8'h30: BCD terminal value of the counter
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, synchronous, active-low
- key_s2  in  1  run/pause key, high = pressed, asynchronous, bouncing
- key_s3  in  1  clear key, high = pressed, asynchronous, bouncing
- cnt_val  in  8  current counter value, BCD (high nibble = DK1)
- cnt_en  out  1  one-cycle step strobe to counter
- cnt_clr  out  1  one-cycle clear strobe to counter
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
- lap_cnt  out  4  BCD count of completed laps, 0–9, saturating
- led_run  out  1  high while state == RUN

## Operation
- Keys: each key passes a 2-flop synchronizer, then a debouncer; a level change is accepted only after DEB_CYCLES consecutive equal synchronized samples. An accepted 0→1 change produces a one-cycle press event (ev_s2, ev_s3). Releases produce no event.
- FSM, all transitions registered:
  - IDLE: ev_s2 → RUN.
  - RUN: ev_s2 → PAUSE. Tick handling below.
  - PAUSE: ev_s2 → RUN.
  - DONE: ev_s2 ignored.
  - Any state: ev_s3 → IDLE, cnt_clr pulses, lap_cnt ← 0. ev_s3 takes priority over a same-cycle ev_s2 and over a same-cycle tick.
- Divider: counts 0..TICK_DIV-1 only while state == RUN; forced to 0 in every other state, so each entry into RUN (including resume from PAUSE) restarts the phase.
- Tick: in RUN, the cycle where divider == TICK_DIV-1 is the tick cycle; cnt_val is sampled in that cycle.
  - cnt_val != LIMIT_BCD: cnt_en pulses.
  - cnt_val == LIMIT_BCD: see Configuration.
- lap_cnt: BCD 0–9; increments on each wrap; holds at 9.
- cnt_val is trusted; non-BCD values are compared bit-exactly, with no correction applied.

## Timing
- Reset values: state = IDLE, cnt_en = 0, cnt_clr = 0, lap_cnt = 0, led_run = 0. Divider, synchronizers and debouncers are cleared; keys are treated as released.
- Key press to event: 2 sync cycles + DEB_CYCLES, then ev_* is valid for one cycle. Bounces shorter than DEB_CYCLES produce no event.
- Event in cycle E: state, cnt_clr and lap_cnt update at the E+1 clock edge.
- cnt_en and cnt_clr are registered and high for exactly one cycle. They are never high in the same cycle.
- Steps: the first cnt_en is high TICK_DIV cycles after state first reads RUN; later steps follow every TICK_DIV cycles.
- rst low mid-operation: all outputs return to reset values on that edge; no cnt_clr is issued (the counter has its own reset).

## Configuration
- Macro: DECIMAL_CNT_CTRL_AUTO_STOP_EN.
- Not defined: a tick with cnt_val == LIMIT_BCD pulses cnt_en (the counter wraps to 00 itself) and increments lap_cnt. State stays RUN. DONE is unreachable.
- Defined: a tick with cnt_val == LIMIT_BCD issues no cnt_en, increments lap_cnt and moves to DONE. The counter holds at LIMIT_BCD. Only ev_s3 leaves DONE.

## Test plan
Bench uses TICK_DIV=4, DEB_CYCLES=3, LIMIT_BCD=8'h03.
- Reset, then press S2 cleanly → event 5 cycles after the press; state=1, led_run=1; cnt_en pulses every 4 cycles, first one 4 cycles after state=1.
- S2 glitches of 2 cycles repeated 5 times → no event; state stays 0.
- RUN, press S2 → state=2, no cnt_en while paused; press S2 again → state=1 and next cnt_en exactly 4 cycles later.
- Macro undefined, cnt_val model counts 00..03 → at tick with cnt_val=03, cnt_en=1 and lap_cnt 0→1; after 10 laps lap_cnt=9.
- Macro defined, cnt_val=03 at tick → no cnt_en, state=3; S2 ignored; S3 → cnt_clr one cycle, state=0, lap_cnt=0.
- S2 and S3 events in the same cycle during RUN → state=0, cnt_clr=1, no cnt_en. rst low mid-RUN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/decimal_cnt_ctrl.sv
// Run/pause/clear controller for a two-digit BCD up-counter: debounced keys, tick pacing, lap tracking.
// Optional build macro DECIMAL_CNT_CTRL_AUTO_STOP_EN: stop in DONE at LIMIT_BCD instead of wrapping.

module decimal_cnt_key_deb #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // New level held for DEB_CYCLES samples; only a rising level is a press.
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module decimal_cnt_ctrl #(
    parameter int          TICK_DIV   = 5_000_000,
    parameter int          DEB_CYCLES = 1_000_000,
    parameter logic [7:0]  LIMIT_BCD  = 8'h30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_s2,
    input  logic       key_s3,
    input  logic [7:0] cnt_val,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic [3:0] lap_cnt,
    output logic       led_run
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    state_t        st;
    logic          ev_s2;
    logic          ev_s3;
    logic [DW-1:0] div;
    logic          tick;

    decimal_cnt_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s2 (
        .clk   (clk),
        .rst   (rst),
        .key   (key_s2),
        .press (ev_s2)
    );

    decimal_cnt_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s3 (
        .clk   (clk),
        .rst   (rst),
        .key   (key_s3),
        .press (ev_s3)
    );

    // Held at zero outside RUN so every entry into RUN restarts a full tick period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
        end else if (st != ST_RUN || div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign tick  = (st == ST_RUN) && (div == DIV_LAST);
    assign state = st;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st      <= ST_IDLE;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            lap_cnt <= 4'd0;
            led_run <= 1'b0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            if (ev_s3) begin
                // Clear wins over a same-cycle run/pause press and a same-cycle tick.
                st      <= ST_IDLE;
                led_run <= 1'b0;
                cnt_clr <= 1'b1;
                lap_cnt <= 4'd0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (ev_s2) begin
                            st      <= ST_RUN;
                            led_run <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (ev_s2) begin
                            st      <= ST_PAUSE;
                            led_run <= 1'b0;
                        end
                        if (tick) begin
                            if (cnt_val == LIMIT_BCD) begin
                                lap_cnt <= (lap_cnt == 4'd9) ? 4'd9 : lap_cnt + 4'd1;
`ifdef DECIMAL_CNT_CTRL_AUTO_STOP_EN
                                st      <= ST_DONE;
                                led_run <= 1'b0;
`else
                                cnt_en  <= 1'b1;
`endif
                            end else begin
                                cnt_en <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (ev_s2) begin
                            st      <= ST_RUN;
                            led_run <= 1'b1;
                        end
                    end
                    default: begin
                        st <= st;
                    end
                endcase
            end
        end
    end
endmodule
